// File: rtl/fib_sum_core.sv
// rtl/fib_sum_core.sv - Fibonacci filter-accumulator with start/busy/done handshake
// Sums Fibonacci terms up to a latched limit that pass an all/even/odd/div-by-3 filter.
module fib_sum_core #(
    parameter int          WIDTH     = 32,
    parameter int          CNTW      = 8,
    parameter int          AUTOSTART = 0,
    parameter int unsigned DEF_LIMIT = 4000000,
    parameter int unsigned DEF_MODE  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             isEnd,
    output logic [WIDTH-1:0] sum,
    output logic [CNTW-1:0]  count,
    output logic             overflow
);

    // Two guard bits keep the term pair from wrapping before a > limit is seen.
    localparam int TW = WIDTH + 2;

    localparam logic [WIDTH-1:0] AUTO_LIMIT = WIDTH'(DEF_LIMIT);
    localparam logic [1:0]       AUTO_MODE  = 2'(DEF_MODE);
    localparam logic             AUTO_EN    = (AUTOSTART != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [TW-1:0]    a, a_n;
    logic [TW-1:0]    b, b_n;
    logic [1:0]       ra, ra_n;
    logic [1:0]       rb, rb_n;
    logic [WIDTH-1:0] lim, lim_n;
    logic [1:0]       md, md_n;
    logic [WIDTH-1:0] sum_n;
    logic [CNTW-1:0]  count_n;
    logic             overflow_n;
    logic             busy_n;
    logic             end_n;
    logic             auto_pend, auto_pend_n;

    logic             launch;
    logic             past_limit;
    logic             pass;
    logic [WIDTH:0]   add;
    logic [2:0]       rsum;
    logic [1:0]       rmod;

    always_comb begin
        launch     = (state == S_IDLE || state == S_DONE) && (start || auto_pend);
        past_limit = a > {2'b00, lim};
        add        = {1'b0, sum} + {1'b0, a[WIDTH-1:0]};
        rsum       = {1'b0, ra} + {1'b0, rb};
        rmod       = (rsum >= 3'd3) ? 2'(rsum - 3'd3) : rsum[1:0];
        case (md)
            2'd0:    pass = 1'b1;
            2'd1:    pass = ~a[0];
            2'd2:    pass = a[0];
            default: pass = (ra == 2'd0);
        endcase
    end

    always_comb begin
        state_n     = state;
        a_n         = a;
        b_n         = b;
        ra_n        = ra;
        rb_n        = rb;
        lim_n       = lim;
        md_n        = md;
        sum_n       = sum;
        count_n     = count;
        overflow_n  = overflow;
        busy_n      = busy;
        end_n       = isEnd;
        auto_pend_n = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                if (launch) begin
                    lim_n      = auto_pend ? AUTO_LIMIT : limit;
                    md_n       = auto_pend ? AUTO_MODE  : mode;
                    a_n        = TW'(1);
                    b_n        = TW'(2);
                    ra_n       = 2'd1;
                    rb_n       = 2'd2;
                    sum_n      = '0;
                    count_n    = '0;
                    overflow_n = 1'b0;
                    busy_n     = 1'b1;
                    end_n      = 1'b0;
                    state_n    = S_RUN;
                end
            end
            S_RUN: begin
                if (past_limit) begin
                    state_n = S_DONE;
                    busy_n  = 1'b0;
                    end_n   = 1'b1;
                end else begin
                    if (pass) begin
                        if (add[WIDTH]) begin
                            // Saturate and stop; the overflowing term is not counted.
                            sum_n      = '1;
                            overflow_n = 1'b1;
                            state_n    = S_DONE;
                            busy_n     = 1'b0;
                            end_n      = 1'b1;
                        end else begin
                            sum_n   = add[WIDTH-1:0];
                            count_n = count + CNTW'(1);
                        end
                    end
                    a_n  = b;
                    b_n  = a + b;
                    ra_n = rb;
                    rb_n = rmod;
                end
            end
            default: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
                end_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            a         <= '0;
            b         <= '0;
            ra        <= '0;
            rb        <= '0;
            lim       <= '0;
            md        <= '0;
            sum       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            isEnd     <= 1'b0;
            auto_pend <= AUTO_EN;
        end else begin
            state     <= state_n;
            a         <= a_n;
            b         <= b_n;
            ra        <= ra_n;
            rb        <= rb_n;
            lim       <= lim_n;
            md        <= md_n;
            sum       <= sum_n;
            count     <= count_n;
            overflow  <= overflow_n;
            busy      <= busy_n;
            isEnd     <= end_n;
            auto_pend <= auto_pend_n;
        end
    end

endmodule

// File: tb/tb_fib_sum_core.sv
// tb/tb_fib_sum_core.sv - scoreboard bench for fib_sum_core (32-bit, 8-bit and autostart instances)
module tb_fib_sum_core;

    logic       clk;
    logic [2:0] rst;
    logic [2:0] st;
    logic [31:0] lim_a, lim_c;
    logic [7:0]  lim_b;
    logic [1:0]  md_a, md_b, md_c;

    wire  [2:0]  busy_w, end_w, ovf_w;
    wire  [31:0] sum_a, sum_c;
    wire  [7:0]  sum_b;
    wire  [7:0]  cnt_a, cnt_b, cnt_c;
    wire  [2:0][31:0] sum_w;
    wire  [2:0][7:0]  cnt_w;

    assign sum_w[0] = sum_a;
    assign sum_w[1] = {24'd0, sum_b};
    assign sum_w[2] = sum_c;
    assign cnt_w[0] = cnt_a;
    assign cnt_w[1] = cnt_b;
    assign cnt_w[2] = cnt_c;

    fib_sum_core #(.WIDTH(32), .CNTW(8)) u_w32 (
        .clk(clk), .reset(rst[0]), .start(st[0]), .limit(lim_a), .mode(md_a),
        .busy(busy_w[0]), .isEnd(end_w[0]), .sum(sum_a), .count(cnt_a), .overflow(ovf_w[0])
    );

    fib_sum_core #(.WIDTH(8), .CNTW(8)) u_w8 (
        .clk(clk), .reset(rst[1]), .start(st[1]), .limit(lim_b), .mode(md_b),
        .busy(busy_w[1]), .isEnd(end_w[1]), .sum(sum_b), .count(cnt_b), .overflow(ovf_w[1])
    );

    fib_sum_core #(.WIDTH(32), .CNTW(8), .AUTOSTART(1)) u_auto (
        .clk(clk), .reset(rst[2]), .start(st[2]), .limit(lim_c), .mode(md_c),
        .busy(busy_w[2]), .isEnd(end_w[2]), .sum(sum_c), .count(cnt_c), .overflow(ovf_w[2])
    );

    typedef struct {
        int     d;
        longint s;
        int     c;
        int     o;
        int     lat;
        int     e0;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    logic [2:0] prev_end = 3'b000;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Reference: walk the sequence with plain arithmetic and apply the filter rules directly.
    function automatic void model(input longint lim, input int md, input int w,
                                  output longint es, output int ec, output int eo, output int lat);
        longint a, b, t, mx;
        bit     ok;
        a = 1; b = 2; mx = (longint'(1) << w) - 1;
        es = 0; ec = 0; eo = 0; lat = 0;
        for (int k = 1; k < 200; k++) begin
            if (a > lim) begin
                lat = k;
                return;
            end
            ok = (md == 0) || (md == 1 && a % 2 == 0) || (md == 2 && a % 2 == 1) || (md == 3 && a % 3 == 0);
            if (ok) begin
                if (es + a > mx) begin
                    es = mx; eo = 1; lat = k;
                    return;
                end
                es = es + a;
                ec = (ec + 1) % 256;
            end
            t = a + b; a = b; b = t;
        end
    endfunction

    function automatic bit pending(input int d);
        foreach (sbq[i]) if (sbq[i].d == d) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push(input int d, input longint s, input int c, input int o, input int lat, input int e0);
        exp_t e;
        e.d = d; e.s = s; e.c = c; e.o = o; e.lat = lat; e.e0 = e0;
        sbq.push_back(e);
    endtask

    task automatic drop(input int d);
        for (int i = sbq.size() - 1; i >= 0; i--) if (sbq[i].d == d) sbq.delete(i);
    endtask

    task automatic set_in(input int d, input logic s, input longint lim, input int md);
        st[d] = s;
        case (d)
            0: begin lim_a = lim[31:0]; md_a = 2'(md); end
            1: begin lim_b = lim[7:0];  md_b = 2'(md); end
            default: begin lim_c = lim[31:0]; md_c = 2'(md); end
        endcase
    endtask

    // Issue a start and check the post-E0 output state; returns the cycle stamp of E0.
    task automatic start_run(input int d, input longint lim, input int md, output int e0);
        @(negedge clk);
        set_in(d, 1'b1, lim, md);
        @(posedge clk);
        #1;
        st[d] = 1'b0;
        e0 = cyc;
        chk($sformatf("e0_state_d%0d", d), {busy_w[d], end_w[d], ovf_w[d], sum_w[d], cnt_w[d]}, {1'b1, 42'd0});
    endtask

    task automatic wait_done(input int d);
        for (int k = 0; k < 300; k++) begin
            if (!pending(d)) return;
            @(negedge clk);
        end
        chk($sformatf("timeout_d%0d", d), 64'd1, 64'd0);
        drop(d);
    endtask

    task automatic directed(input int d, input longint lim, input int md,
                            input longint s, input int c, input int o, input int lat);
        int e0;
        start_run(d, lim, md, e0);
        push(d, s, c, o, lat, e0);
        wait_done(d);
    endtask

    task automatic random_run(input int d, input longint lim, input int md);
        int e0, ec, eo, lat;
        longint es;
        model(lim, md, (d == 1) ? 8 : 32, es, ec, eo, lat);
        start_run(d, lim, md, e0);
        push(d, es, ec, eo, lat, e0);
        wait_done(d);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (busy_w[i] && end_w[i]) chk($sformatf("busy_and_end_d%0d", i), 64'd1, 64'd0);
            if (end_w[i] && !prev_end[i]) begin
                int idx;
                idx = -1;
                foreach (sbq[j]) if (idx < 0 && sbq[j].d == i) idx = j;
                if (idx < 0) begin
                    chk($sformatf("unexpected_end_d%0d", i), 64'd1, 64'd0);
                end else begin
                    chk($sformatf("sum_d%0d", i),      64'(sum_w[i]), 64'(sbq[idx].s));
                    chk($sformatf("count_d%0d", i),    64'(cnt_w[i]), 64'(sbq[idx].c));
                    chk($sformatf("overflow_d%0d", i), 64'(ovf_w[i]), 64'(sbq[idx].o));
                    chk($sformatf("busy_at_end_d%0d", i), 64'(busy_w[i]), 64'd0);
                    chk($sformatf("latency_d%0d", i),  64'(cyc - sbq[idx].e0), 64'(sbq[idx].lat));
                    sbq.delete(idx);
                end
            end
            prev_end[i] = end_w[i];
        end
    end

    initial begin
        int e0;
        rst = 3'b111;
        st  = 3'b000;
        lim_a = '0; lim_b = '0; lim_c = '0;
        md_a = '0;  md_b = '0;  md_c = '0;
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("reset_state_d%0d", i), {busy_w[i], end_w[i], ovf_w[i], sum_w[i], cnt_w[i]}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 3'b000;
        push(2, 4613732, 11, 0, 33, cyc + 1);

        directed(0, 4000000, 1, 4613732, 11, 0, 33);
        directed(0, 10, 0, 19, 5, 0, 6);
        directed(0, 10, 2, 9, 3, 0, 6);
        directed(0, 100, 3, 24, 2, 0, 11);
        directed(0, 0, 2, 0, 0, 0, 1);
        directed(1, 255, 0, 255, 10, 1, 11);
        directed(1, 0, 0, 0, 0, 0, 1);

        wait_done(2);
        repeat (3) @(negedge clk);
        chk("auto_done_hold", {end_w[2], busy_w[2], sum_w[2]}, {2'b10, 32'd4613732});

        // Reset in the middle of a long run discards it entirely.
        start_run(0, 4000000, 0, e0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst[0] = 1'b1;
        #1;
        chk("midrun_reset_outputs", {busy_w[0], end_w[0], ovf_w[0], sum_w[0], cnt_w[0]}, 64'd0);
        @(negedge clk);
        rst[0] = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", {busy_w[0], end_w[0], ovf_w[0], sum_w[0], cnt_w[0]}, 64'd0);

        // A start pulse with different settings during RUN must not disturb the run.
        start_run(0, 10, 0, e0);
        push(0, 19, 5, 0, 6, e0);
        @(negedge clk);
        set_in(0, 1'b1, 100, 3);
        @(negedge clk);
        set_in(0, 1'b0, 100, 3);
        wait_done(0);

        for (int n = 0; n < 6; n++) begin
            longint l;
            l = (n % 2 == 0) ? longint'($urandom) : longint'($urandom_range(0, 5000));
            random_run(0, l, int'($urandom_range(0, 3)));
        end
        for (int n = 0; n < 6; n++)
            random_run(1, longint'($urandom_range(0, 255)), int'($urandom_range(0, 3)));

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
